// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size and FSM encodings,
// timeout counter width, and byte-lane helpers used when issuing a request.
package mem_stage_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_DONE     = 2'b10
  } state_e;

  // Reserved size behaves as a word access everywhere.
  function automatic logic access_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = (off[0] == 1'b0);
      default:   ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{data[7:0]}};
      SIZE_HALF: lanes = {2{data[15:0]}};
      default:   lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of a little-endian read word and
// zero- or sign-extends it to 32 bits.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    value  = 32'h0000_0000;
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SIZE_BYTE: value = is_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: value = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default:   value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues aligned loads/stores on a req/ack data bus,
// stalls the upstream stage while busy, and retires results to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write_in,
  input  logic [4:0]  write_reg_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_reg_write,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

  state_e             state_r,        state_next;
  logic [CNT_W-1:0]   cnt_r,          cnt_next;
  logic               dmem_req_r,     dmem_req_next;
  logic               dmem_we_r,      dmem_we_next;
  logic [3:0]         dmem_be_r,      dmem_be_next;
  logic [31:0]        dmem_addr_r,    dmem_addr_next;
  logic [31:0]        dmem_wdata_r,   dmem_wdata_next;
  logic               valid_out_r,    valid_out_next;
  logic [31:0]        wb_data_r,      wb_data_next;
  logic [4:0]         wb_reg_r,       wb_reg_next;
  logic               wb_reg_write_r, wb_reg_write_next;
  logic               misaligned_r,   misaligned_next;
  logic               bus_error_r,    bus_error_next;
  logic [1:0]         pend_off_r,     pend_off_next;
  logic [1:0]         pend_size_r,    pend_size_next;
  logic               pend_uns_r,     pend_uns_next;
  logic [4:0]         pend_reg_r,     pend_reg_next;
  logic               pend_rw_r,      pend_rw_next;

  logic               is_mem_s;
  logic               aligned_s;
  logic [31:0]        load_value_s;

  assign is_mem_s  = mem_read | mem_write;
  assign aligned_s = access_aligned(mem_size, alu_result[1:0]);

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr        (pend_off_r),
    .size        (pend_size_r),
    .is_unsigned (pend_uns_r),
    .value       (load_value_s)
  );

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    state_next        = state_r;
    cnt_next          = cnt_r;
    dmem_req_next     = dmem_req_r;
    dmem_we_next      = dmem_we_r;
    dmem_be_next      = dmem_be_r;
    dmem_addr_next    = dmem_addr_r;
    dmem_wdata_next   = dmem_wdata_r;
    valid_out_next    = 1'b0;
    wb_data_next      = wb_data_r;
    wb_reg_next       = wb_reg_r;
    wb_reg_write_next = wb_reg_write_r;
    misaligned_next   = 1'b0;
    bus_error_next    = 1'b0;
    pend_off_next     = pend_off_r;
    pend_size_next    = pend_size_r;
    pend_uns_next     = pend_uns_r;
    pend_reg_next     = pend_reg_r;
    pend_rw_next      = pend_rw_r;

    case (state_r)
      ST_IDLE: begin
        if (valid_in && !is_mem_s) begin
          valid_out_next    = 1'b1;
          wb_data_next      = alu_result;
          wb_reg_next       = write_reg_in;
          wb_reg_write_next = reg_write_in;
        end else if (valid_in && !aligned_s) begin
          valid_out_next    = 1'b1;
          misaligned_next   = 1'b1;
          wb_data_next      = alu_result;
          wb_reg_next       = write_reg_in;
          wb_reg_write_next = 1'b0;
        end else if (valid_in) begin
          // Loads leave be/wdata at zero; only stores drive lanes.
          state_next      = ST_WAIT_ACK;
          cnt_next        = {CNT_W{1'b0}};
          dmem_req_next   = 1'b1;
          dmem_we_next    = mem_write;
          dmem_addr_next  = {alu_result[31:2], 2'b00};
          dmem_be_next    = mem_write ? lane_enable(mem_size, alu_result[1:0]) : 4'b0000;
          dmem_wdata_next = mem_write ? store_lanes(mem_size, store_data) : 32'h0000_0000;
          pend_off_next   = alu_result[1:0];
          pend_size_next  = mem_size;
          pend_uns_next   = mem_unsigned;
          pend_reg_next   = write_reg_in;
          pend_rw_next    = reg_write_in;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (dmem_ack) begin
          state_next     = ST_DONE;
          dmem_req_next  = 1'b0;
          valid_out_next = 1'b1;
          wb_reg_next    = pend_reg_r;
          if (dmem_we_r) begin
            wb_reg_write_next = 1'b0;
          end else begin
            wb_reg_write_next = pend_rw_r;
            wb_data_next      = load_value_s;
          end
        end else if ((cnt_r + 8'd1) == TIMEOUT_CNT) begin
          state_next        = ST_DONE;
          cnt_next          = cnt_r + 8'd1;
          dmem_req_next     = 1'b0;
          valid_out_next    = 1'b1;
          bus_error_next    = 1'b1;
          wb_reg_next       = pend_reg_r;
          wb_reg_write_next = 1'b0;
        end else begin
          cnt_next = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next    = ST_IDLE;
        dmem_req_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      dmem_req_r     <= 1'b0;
      dmem_we_r      <= 1'b0;
      dmem_be_r      <= 4'b0000;
      dmem_addr_r    <= 32'h0000_0000;
      dmem_wdata_r   <= 32'h0000_0000;
      valid_out_r    <= 1'b0;
      wb_data_r      <= 32'h0000_0000;
      wb_reg_r       <= 5'd0;
      wb_reg_write_r <= 1'b0;
      misaligned_r   <= 1'b0;
      bus_error_r    <= 1'b0;
      pend_off_r     <= 2'b00;
      pend_size_r    <= 2'b00;
      pend_uns_r     <= 1'b0;
      pend_reg_r     <= 5'd0;
      pend_rw_r      <= 1'b0;
    end else begin
      state_r        <= state_next;
      cnt_r          <= cnt_next;
      dmem_req_r     <= dmem_req_next;
      dmem_we_r      <= dmem_we_next;
      dmem_be_r      <= dmem_be_next;
      dmem_addr_r    <= dmem_addr_next;
      dmem_wdata_r   <= dmem_wdata_next;
      valid_out_r    <= valid_out_next;
      wb_data_r      <= wb_data_next;
      wb_reg_r       <= wb_reg_next;
      wb_reg_write_r <= wb_reg_write_next;
      misaligned_r   <= misaligned_next;
      bus_error_r    <= bus_error_next;
      pend_off_r     <= pend_off_next;
      pend_size_r    <= pend_size_next;
      pend_uns_r     <= pend_uns_next;
      pend_reg_r     <= pend_reg_next;
      pend_rw_r      <= pend_rw_next;
    end
  end

  assign stall        = (state_r != ST_IDLE);
  assign dmem_req     = dmem_req_r;
  assign dmem_we      = dmem_we_r;
  assign dmem_be      = dmem_be_r;
  assign dmem_addr    = dmem_addr_r;
  assign dmem_wdata   = dmem_wdata_r;
  assign valid_out    = valid_out_r;
  assign wb_data      = wb_data_r;
  assign wb_reg       = wb_reg_r;
  assign wb_reg_write = wb_reg_write_r;
  assign misaligned   = misaligned_r;
  assign bus_error    = bus_error_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, randomized transactions
// against a behavioural model, and a reset-during-access sequence.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clock, reset, valid_in;
  logic [31:0] alu_result, store_data;
  logic        mem_read, mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned, reg_write_in;
  logic [4:0]  write_reg_in;
  logic        stall, dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack, valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_reg_write, misaligned, bus_error;

  int checks = 0;
  int failures = 0;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write_in(reg_write_in),
    .write_reg_in(write_reg_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_out(valid_out),
    .wb_data(wb_data), .wb_reg(wb_reg), .wb_reg_write(wb_reg_write),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu, sdata, rdata;
    logic        rw;
    logic [4:0]  rg;
    int          delay;
    int          e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata, e_wb;
    logic        e_rw, e_mis, e_berr;
  } vec_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] alu, sdata, rdata, input logic rw,
                              input logic [4:0] rg, input int delay, input int e_req,
                              input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                              input logic [31:0] e_wdata, e_wb, input logic e_rw, e_mis, e_berr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.alu = alu; v.sdata = sdata;
    v.rdata = rdata; v.rw = rw; v.rg = rg; v.delay = delay; v.e_req = e_req;
    v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we; v.e_wdata = e_wdata; v.e_wb = e_wb;
    v.e_rw = e_rw; v.e_mis = e_mis; v.e_berr = e_berr;
    return v;
  endfunction

  // Reference model: expectations from access size in bytes and plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nbytes, off;
    logic [31:0] mask, raw;
    r = v;
    off = int'(v.alu[1:0]);
    nbytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    r.e_req = 0; r.e_addr = 32'h0; r.e_be = 4'h0; r.e_we = 1'b0; r.e_wdata = 32'h0;
    r.e_wb = 32'h0; r.e_rw = 1'b0; r.e_mis = 1'b0; r.e_berr = 1'b0;
    if (!(v.rd || v.wr)) begin
      r.e_wb = v.alu;
      r.e_rw = v.rw;
    end else if ((off % nbytes) != 0) begin
      r.e_mis = 1'b1;
    end else begin
      r.e_addr = v.alu & 32'hFFFF_FFFC;
      r.e_we = v.wr;
      if (v.wr) begin
        r.e_be = 4'(((1 << nbytes) - 1) << off);
        r.e_wdata = (nbytes == 1) ? v.sdata[7:0] * 32'h0101_0101 :
                    (nbytes == 2) ? v.sdata[15:0] * 32'h0001_0001 : v.sdata;
      end
      if (v.delay < TO) begin
        r.e_req = v.delay + 1;
        r.e_rw = v.wr ? 1'b0 : v.rw;
        if (!v.wr) begin
          mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 32'd1;
          raw = (v.rdata >> (8 * off)) & mask;
          if (!v.uns && raw[8 * nbytes - 1]) raw = raw | ~mask;
          r.e_wb = raw;
        end
      end else begin
        r.e_req = TO;
        r.e_berr = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input string name);
    int  req_cycles;
    bit  done;
    logic [31:0] samp;
    valid_in = 1'b1; alu_result = v.alu; store_data = v.sdata; mem_read = v.rd;
    mem_write = v.wr; mem_size = v.size; mem_unsigned = v.uns; reg_write_in = v.rw;
    write_reg_in = v.rg; dmem_ack = 1'b0;
    step();
    if (v.e_req == 0) begin
      valid_in = 1'b0;
      check({name, " valid_out"}, valid_out, 1'b1);
      check({name, " stall"}, stall, 1'b0);
      check({name, " no_req"}, dmem_req, 1'b0);
      check({name, " misaligned"}, misaligned, v.e_mis);
      check({name, " bus_error"}, bus_error, 1'b0);
      check({name, " wb_reg_write"}, wb_reg_write, v.e_rw);
      check({name, " wb_reg"}, wb_reg, v.rg);
      if (!v.e_mis) check({name, " wb_data"}, wb_data, v.e_wb);
      step();
      check({name, " valid_pulse"}, valid_out, 1'b0);
      check({name, " mis_pulse"}, misaligned, 1'b0);
    end else begin
      req_cycles = 0;
      done = 1'b0;
      for (int k = 0; k < 16 && !done; k++) begin
        if (valid_out) begin
          done = 1'b1;
        end else begin
          req_cycles++;
          check({name, " req"}, dmem_req, 1'b1);
          check({name, " stall"}, stall, 1'b1);
          check({name, " addr"}, dmem_addr, v.e_addr);
          check({name, " we"}, dmem_we, v.e_we);
          check({name, " be"}, dmem_be, v.e_be);
          if (v.e_we) check({name, " wdata"}, dmem_wdata, v.e_wdata);
          samp = $urandom;
          alu_result = samp; store_data = ~samp; mem_size = samp[1:0];
          mem_read = samp[2]; mem_write = samp[3];
          dmem_ack = (k == v.delay);
          dmem_rdata = (k == v.delay) ? v.rdata : $urandom;
          step();
        end
      end
      check({name, " retired_in_budget"}, 32'(done), 32'd1);
      check({name, " req_cycles"}, req_cycles, v.e_req);
      check({name, " req_dropped"}, dmem_req, 1'b0);
      check({name, " stall_done"}, stall, 1'b1);
      check({name, " bus_error"}, bus_error, v.e_berr);
      check({name, " misaligned"}, misaligned, 1'b0);
      check({name, " wb_reg_write"}, wb_reg_write, v.e_rw);
      check({name, " wb_reg"}, wb_reg, v.rg);
      if (!v.e_we && !v.e_berr) check({name, " wb_data"}, wb_data, v.e_wb);
      valid_in = 1'b0;
      dmem_ack = 1'b1;
      step();
      check({name, " valid_pulse"}, valid_out, 1'b0);
      check({name, " berr_pulse"}, bus_error, 1'b0);
      check({name, " stall_clear"}, stall, 1'b0);
      check({name, " late_ack_no_req"}, dmem_req, 1'b0);
      dmem_ack = 1'b0;
      step();
      check({name, " late_ack_ignored"}, valid_out, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  vec_t rv;

  initial begin
    reset = 1'b0; valid_in = 1'b0; alu_result = 32'h0; store_data = 32'h0;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    reg_write_in = 1'b0; write_reg_in = 5'd0; dmem_rdata = 32'h0; dmem_ack = 1'b0;

    tbl[0]  = mk(0,0,2'd2,0, 32'h0000_1234, 32'h0, 32'h0, 1,5'd5, 0, 0, 32'h0,4'h0,0,32'h0, 32'h0000_1234, 1,0,0);
    tbl[1]  = mk(1,0,2'd0,0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1,5'd7, 2, 3, 32'h100,4'h0,0,32'h0, 32'hFFFF_FF80, 1,0,0);
    tbl[2]  = mk(0,1,2'd1,0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1,5'd8, 0, 1, 32'h200,4'b1100,1,32'hABCD_ABCD, 32'h0, 0,0,0);
    tbl[3]  = mk(1,0,2'd2,0, 32'h0000_0006, 32'h0, 32'h0, 1,5'd9, 0, 0, 32'h0,4'h0,0,32'h0, 32'h0, 0,1,0);
    tbl[4]  = mk(1,0,2'd2,0, 32'h0000_0040, 32'h0, 32'h1111_1111, 1,5'd10, 99, 4, 32'h40,4'h0,0,32'h0, 32'h0, 0,0,1);
    tbl[5]  = mk(1,0,2'd1,1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1,5'd11, 3, 4, 32'h0,4'h0,0,32'h0, 32'h0000_8001, 1,0,0);
    tbl[6]  = mk(0,1,2'd0,0, 32'h0000_0001, 32'h0000_005A, 32'h0, 1,5'd12, 1, 2, 32'h0,4'b0010,1,32'h5A5A_5A5A, 32'h0, 0,0,0);
    tbl[7]  = mk(0,1,2'd2,0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1,5'd13, 0, 1, 32'h10,4'b1111,1,32'hDEAD_BEEF, 32'h0, 0,0,0);
    tbl[8]  = mk(1,0,2'd1,0, 32'h0000_0000, 32'h0, 32'h1234_8765, 1,5'd14, 0, 1, 32'h0,4'h0,0,32'h0, 32'hFFFF_8765, 1,0,0);
    tbl[9]  = mk(1,0,2'd3,1, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1,5'd15, 1, 2, 32'h8,4'h0,0,32'h0, 32'hCAFE_F00D, 1,0,0);
    tbl[10] = mk(0,1,2'd1,0, 32'h0000_0003, 32'hAAAA_5555, 32'h0, 1,5'd16, 0, 0, 32'h0,4'h0,0,32'h0, 32'h0, 0,1,0);
    tbl[11] = mk(1,1,2'd0,0, 32'h0000_0002, 32'h0000_00C3, 32'h5555_5555, 1,5'd17, 0, 1, 32'h0,4'b0100,1,32'hC3C3_C3C3, 32'h0, 0,0,0);
    tbl[12] = mk(0,0,2'd0,0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0,5'd31, 0, 0, 32'h0,4'h0,0,32'h0, 32'hFFFF_FFFF, 0,0,0);
    tbl[13] = mk(1,0,2'd0,1, 32'h0000_0003, 32'h0, 32'h80FF_0000, 1,5'd18, 0, 1, 32'h0,4'h0,0,32'h0, 32'h0000_0080, 1,0,0);

    // Reset values while reset is held low.
    @(posedge clock); @(posedge clock); #1;
    check("rst stall", stall, 1'b0);
    check("rst dmem_req", dmem_req, 1'b0);
    check("rst dmem_we", dmem_we, 1'b0);
    check("rst dmem_be", dmem_be, 4'h0);
    check("rst dmem_addr", dmem_addr, 32'h0);
    check("rst dmem_wdata", dmem_wdata, 32'h0);
    check("rst valid_out", valid_out, 1'b0);
    check("rst wb_data", wb_data, 32'h0);
    check("rst wb_reg", wb_reg, 5'd0);
    check("rst wb_reg_write", wb_reg_write, 1'b0);
    check("rst misaligned", misaligned, 1'b0);
    check("rst bus_error", bus_error, 1'b0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted during WAIT_ACK, then a stray ack after release.
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
    alu_result = 32'h0000_0100; reg_write_in = 1'b1; write_reg_in = 5'd3;
    step();
    check("mid_rst req_before", dmem_req, 1'b1);
    check("mid_rst stall_before", stall, 1'b1);
    step();
    reset = 1'b0; valid_in = 1'b0;
    #1;
    check("mid_rst stall_async", stall, 1'b0);
    check("mid_rst req_async", dmem_req, 1'b0);
    check("mid_rst addr_async", dmem_addr, 32'h0);
    step();
    reset = 1'b1;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_rst valid_out c%0d", k), valid_out, 1'b0);
      check($sformatf("mid_rst stall c%0d", k), stall, 1'b0);
      check($sformatf("mid_rst req c%0d", k), dmem_req, 1'b0);
      step();
    end
    apply(tbl[7], "post_rst");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      rv.rd = (kind == 1) || (kind == 3);
      rv.wr = (kind == 2) || (kind == 3);
      rv.size = 2'($urandom_range(0, 3));
      rv.uns = 1'($urandom_range(0, 1));
      rv.alu = $urandom;
      rv.sdata = $urandom;
      rv.rdata = $urandom;
      rv.rw = 1'($urandom_range(0, 1));
      rv.rg = 5'($urandom_range(0, 31));
      rv.delay = $urandom_range(0, 5);
      apply(model(rv), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
